mealy_prog: RTL and testbench
=============================

Name: mealy_prog

Overview:
Programmable, table-driven Mealy state machine: next state and output come from a run-time-loadable transition table indexed by {present state, input symbol}. This is the generic successor to our hard-coded small Mealy controllers. Control logic loads a behaviour once through the cfg port, then streams symbols in. It adds a synchronous restart, input qualification, write checking and a step counter.

Parameters:
IN_W, 2, input symbol width
ST_W, 3, state encoding width
OUT_W, 1, output width
N_STATES, 5, number of legal states; must satisfy N_STATES <= 2**ST_W
START_STATE, 0, state entered on reset or restart; must be < N_STATES
CNT_W, 16, step counter width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  enables stepping
restart  in  1  synchronous return to START_STATE
data_valid  in  1  data_in qualifies this cycle
data_in  in  IN_W  input symbol
data_out  out  OUT_W  Mealy output
pres_state  out  ST_W  current state
cfg_we  in  1  table write strobe
cfg_state  in  ST_W  table row (present state)
cfg_in  in  IN_W  table column (input symbol)
cfg_next  in  ST_W  next state to store
cfg_out  in  OUT_W  output to store
cfg_err  out  1  rejected-write pulse
step_cnt  out  CNT_W  accepted-step count

Behaviour:
- Table size: 2**(ST_W+IN_W) entries, each {next: ST_W, out: OUT_W}. Index = {state, symbol}.
- Reset (reset=0, asynchronous):
  - pres_state=START_STATE, step_cnt=0, cfg_err=0.
  - Every table entry becomes next=START_STATE, out=0.
- step = run & data_valid & ~restart.
- data_out (combinational) = table[pres_state, data_in].out when step, else 0. Zero latency from data_in.
- On a clock edge with step=1: pres_state <= table[pres_state, data_in].next. step_cnt increments, saturating at all-ones.
- On a clock edge with restart=1: pres_state <= START_STATE and step_cnt <= 0, regardless of run, data_valid or data_in. Restart has priority over step.
- run=0 or data_valid=0: pres_state and step_cnt hold; data_out=0.
- Table write on a clock edge with cfg_we=1:
  - Accepted only when cfg_state < N_STATES and cfg_next < N_STATES.
  - Otherwise the write is discarded and cfg_err=1 for exactly the next cycle. cfg_err is registered and is 0 in all other cycles.
- Writes are accepted independently of run and restart.
- Write and lookup hitting the same entry in the same cycle: the lookup (data_out and next state) uses the old contents. The new contents are visible from the next cycle.
- Defensive decode: if pres_state >= N_STATES (unreachable through legal writes), data_out=0 and the next step goes to START_STATE.
- Symbols with no programmed entry behave as the reset entry: go to START_STATE, output 0.

Optional Feature:
MEALY_PROG_REGOUT_EN
- Defined: data_out is registered, one cycle after the step that produced it.
  - Holds 0 in cycles following a non-step or a restart.
  - Reset value is 0.
  - pres_state timing is unchanged.
- Undefined: data_out is combinational, as described in Behaviour.

Test Plan:
- Reset then idle, no writes: pres_state=START_STATE, data_out=0, step_cnt=0. Stream data_in=2'b11 with run=1, data_valid=1 for 4 cycles -> pres_state stays 0, data_out=0, step_cnt=4.
- Program (0,2'b01)->next 4, out 1 and (4,2'b11)->next 4, out 1. Drive 01, 11, 11 -> data_out=1 in the same cycle as each symbol; pres_state sequence 0→4→4→4; step_cnt=3.
- Write cfg_state=5 or cfg_next=7 with N_STATES=5 -> cfg_err=1 for one cycle; table readback by stepping shows the old entry unchanged.
- In state 4, assert restart together with data_valid and data_in=11 -> next cycle pres_state=0, step_cnt=0, data_out=0 during the restart cycle.
- Same-cycle write of (0,2'b10)->next 2 and a step from state 0 with 10 -> old next (0) is taken. A repeat step with 10 goes to state 2.
- CNT_W=3: apply 10 steps -> step_cnt saturates at 7. With MEALY_PROG_REGOUT_EN defined, the scenario-2 outputs appear exactly one cycle later.

Source files
------------

// File: rtl/mealy_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mealy_prog                                                  |
// | Description: Programmable table-driven Mealy machine. The transition     |
// |              table is loaded at run time through the cfg port and is     |
// |              indexed by {present state, input symbol}. Includes a        |
// |              synchronous restart, input qualification, write checking    |
// |              and a saturating step counter.                              |
// |              Optional: define MEALY_PROG_REGOUT_EN to register data_out. |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module mealy_prog #(
    parameter int IN_W        = 2,
    parameter int ST_W        = 3,
    parameter int OUT_W       = 1,
    parameter int N_STATES    = 5,
    parameter int START_STATE = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             restart,
    input  logic             data_valid,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] data_out,
    output logic [ST_W-1:0]  pres_state,
    input  logic             cfg_we,
    input  logic [ST_W-1:0]  cfg_state,
    input  logic [IN_W-1:0]  cfg_in,
    input  logic [ST_W-1:0]  cfg_next,
    input  logic [OUT_W-1:0] cfg_out,
    output logic             cfg_err,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int              c_idx_w    = ST_W + IN_W;
    localparam int              c_depth    = 2 ** c_idx_w;
    localparam int              c_ent_w    = ST_W + OUT_W;
    localparam logic [ST_W-1:0] c_start    = ST_W'(START_STATE);
    localparam logic [ST_W:0]   c_n_states = (ST_W + 1)'(N_STATES);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic                 w_step;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_idx_w-1:0]   w_cfg_idx;
    logic                 w_cfg_ok;
    logic [c_ent_w-1:0]   w_table [c_depth];
    logic [c_ent_w-1:0]   w_entry;
    logic                 w_st_legal;
    logic [ST_W-1:0]      w_next;
    logic [OUT_W-1:0]     w_out_lut;

    logic [ST_W-1:0]      r_pres_state;
    logic [CNT_W-1:0]     r_step_cnt;
    logic                 r_cfg_err;

    assign w_step    = run & data_valid & ~restart;
    assign w_idx     = {r_pres_state, data_in};
    assign w_cfg_idx = {cfg_state, cfg_in};
    assign w_cfg_ok  = ({1'b0, cfg_state} < c_n_states) &&
                       ({1'b0, cfg_next}  < c_n_states);

    // One register per table entry; lookups read the pre-write contents.
    generate
        for (genvar gi = 0; gi < c_depth; gi++) begin : g_entry
            logic [c_ent_w-1:0] r_ent;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_ent <= {c_start, {OUT_W{1'b0}}};
                end else if (cfg_we && w_cfg_ok &&
                             (w_cfg_idx == c_idx_w'(gi))) begin
                    r_ent <= {cfg_next, cfg_out};
                end
            end

            assign w_table[gi] = r_ent;
        end
    endgenerate

    assign w_entry    = w_table[w_idx];
    assign w_st_legal = ({1'b0, r_pres_state} < c_n_states);
    // An illegal present state falls back to the start state with zero output.
    assign w_next     = w_st_legal ? w_entry[c_ent_w-1 -: ST_W] : c_start;
    assign w_out_lut  = w_st_legal ? w_entry[OUT_W-1:0] : {OUT_W{1'b0}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pres_state <= c_start;
            r_step_cnt   <= {CNT_W{1'b0}};
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we & ~w_cfg_ok;
            if (restart) begin
                r_pres_state <= c_start;
                r_step_cnt   <= {CNT_W{1'b0}};
            end else if (w_step) begin
                r_pres_state <= w_next;
                if (r_step_cnt != c_cnt_max) begin
                    r_step_cnt <= r_step_cnt + 1'b1;
                end
            end
        end
    end

`ifdef MEALY_PROG_REGOUT_EN
    logic [OUT_W-1:0] r_data_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data_out <= {OUT_W{1'b0}};
        end else begin
            r_data_out <= w_step ? w_out_lut : {OUT_W{1'b0}};
        end
    end

    assign data_out = r_data_out;
`else
    assign data_out = w_step ? w_out_lut : {OUT_W{1'b0}};
`endif

    assign pres_state = r_pres_state;
    assign step_cnt   = r_step_cnt;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_mealy_prog.sv
`default_nettype none
// Testbench for mealy_prog: directed vectors checked against an array-based
// behavioural model every cycle, plus hand-computed literal checkpoints.
module tb_mealy_prog;

    localparam int IN_W  = 2;
    localparam int ST_W  = 3;
    localparam int OUT_W = 1;
    localparam int NST   = 5;
    localparam int START = 0;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic             run;
    logic             restart;
    logic             data_valid;
    logic [IN_W-1:0]  data_in;
    logic [OUT_W-1:0] data_out;
    logic [ST_W-1:0]  pres_state;
    logic             cfg_we;
    logic [ST_W-1:0]  cfg_state;
    logic [IN_W-1:0]  cfg_in;
    logic [ST_W-1:0]  cfg_next;
    logic [OUT_W-1:0] cfg_out;
    logic             cfg_err;
    logic [CNT_W-1:0] step_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    mealy_prog #(
        .IN_W(IN_W), .ST_W(ST_W), .OUT_W(OUT_W),
        .N_STATES(NST), .START_STATE(START), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .restart(restart),
        .data_valid(data_valid), .data_in(data_in), .data_out(data_out),
        .pres_state(pres_state), .cfg_we(cfg_we), .cfg_state(cfg_state),
        .cfg_in(cfg_in), .cfg_next(cfg_next), .cfg_out(cfg_out),
        .cfg_err(cfg_err), .step_cnt(step_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arrays for the table, integers for state/count.
    int m_next [8][4];
    int m_out  [8][4];
    int m_st;
    int m_cnt;
    int m_err;
    int m_dreg;

    function automatic int f_out();
        if (!(run && data_valid && !restart)) return 0;
        if (m_st >= NST) return 0;
        return m_out[m_st][data_in];
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 4; j++) begin
                    m_next[i][j] <= START;
                    m_out[i][j]  <= 0;
                end
            m_st   <= START;
            m_cnt  <= 0;
            m_err  <= 0;
            m_dreg <= 0;
        end else begin
            m_err  <= (cfg_we && !(cfg_state < NST && cfg_next < NST)) ? 1 : 0;
            if (cfg_we && cfg_state < NST && cfg_next < NST) begin
                m_next[cfg_state][cfg_in] <= int'(cfg_next);
                m_out[cfg_state][cfg_in]  <= int'(cfg_out);
            end
            m_dreg <= f_out();
            if (restart) begin
                m_st  <= START;
                m_cnt <= 0;
            end else if (run && data_valid) begin
                m_st  <= (m_st < NST) ? m_next[m_st][data_in] : START;
                m_cnt <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            end
        end
    end

    always @(negedge clock) begin
        check("pres_state", 32'(pres_state), m_st);
        check("step_cnt", 32'(step_cnt), m_cnt);
        check("cfg_err", 32'(cfg_err), m_err);
`ifdef MEALY_PROG_REGOUT_EN
        check("data_out", 32'(data_out), m_dreg);
`else
        check("data_out", 32'(data_out), f_out());
`endif
    end

    task automatic set_in(input logic r, input logic rs, input logic dv, input logic [1:0] d);
        run = r; restart = rs; data_valid = dv; data_in = d;
    endtask

    task automatic set_cfg(input logic we, input logic [2:0] cs, input logic [1:0] ci,
                           input logic [2:0] cn, input logic co);
        cfg_we = we; cfg_state = cs; cfg_in = ci; cfg_next = cn; cfg_out = co;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 2'b00);
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("lit_reset_state", 32'(pres_state), 0);
        check("lit_reset_cnt", 32'(step_cnt), 0);
        check("lit_reset_err", 32'(cfg_err), 0);
        check("lit_reset_dout", 32'(data_out), 0);
        reset = 1'b1;

        // Unprogrammed table: stays in state 0, output 0, counter counts.
        set_in(1, 0, 1, 2'b11);
        repeat (4) tick();
        check("lit_idle_cnt", 32'(step_cnt), 4);
        check("lit_idle_state", 32'(pres_state), 0);

        set_in(0, 0, 1, 2'b11);
        repeat (2) tick();
        set_in(1, 0, 0, 2'b11);
        tick();
        check("lit_hold_cnt", 32'(step_cnt), 4);

        set_in(0, 1, 0, 2'b00);
        tick();
        check("lit_restart_cnt", 32'(step_cnt), 0);

        // Program (0,01)->4/1 and (4,11)->4/1.
        set_in(0, 0, 0, 2'b00);
        set_cfg(1, 3'd0, 2'b01, 3'd4, 1'b1);
        tick();
        set_cfg(1, 3'd4, 2'b11, 3'd4, 1'b1);
        tick();
        set_cfg(0, 0, 0, 0, 0);

        set_in(1, 0, 1, 2'b01);
`ifndef MEALY_PROG_REGOUT_EN
        #1;
        check("lit_s2_dout_same_cycle", 32'(data_out), 1);
`endif
        tick();
        check("lit_s2_state_a", 32'(pres_state), 4);
`ifdef MEALY_PROG_REGOUT_EN
        check("lit_s2_dout_delayed", 32'(data_out), 1);
`endif
        set_in(1, 0, 1, 2'b11);
        repeat (2) tick();
        check("lit_s2_state_b", 32'(pres_state), 4);
        check("lit_s2_cnt", 32'(step_cnt), 3);
        check("lit_s2_dout_last", 32'(data_out), 1);

        // Illegal writes are rejected with a one-cycle error pulse.
        set_in(0, 0, 0, 2'b00);
        set_cfg(1, 3'd5, 2'b01, 3'd1, 1'b1);
        tick();
        check("lit_err_bad_state", 32'(cfg_err), 1);
        set_cfg(1, 3'd0, 2'b01, 3'd7, 1'b0);
        tick();
        check("lit_err_bad_next", 32'(cfg_err), 1);
        set_cfg(0, 0, 0, 0, 0);
        tick();
        check("lit_err_clear", 32'(cfg_err), 0);

        set_in(0, 1, 0, 2'b00);
        tick();
        set_in(1, 0, 1, 2'b01);
        tick();
        check("lit_readback_state", 32'(pres_state), 4);

        // Restart beats a simultaneous qualified step.
        set_in(1, 1, 1, 2'b11);
`ifndef MEALY_PROG_REGOUT_EN
        #1;
        check("lit_restart_dout", 32'(data_out), 0);
`endif
        tick();
        check("lit_restart_state", 32'(pres_state), 0);
        check("lit_restart_cnt2", 32'(step_cnt), 0);
`ifdef MEALY_PROG_REGOUT_EN
        check("lit_restart_dout_reg", 32'(data_out), 0);
`endif

        // Same-cycle write and lookup: old entry wins, new entry next cycle.
        set_in(1, 0, 1, 2'b10);
        set_cfg(1, 3'd0, 2'b10, 3'd2, 1'b0);
        tick();
        check("lit_wr_collide_old", 32'(pres_state), 0);
        set_cfg(0, 0, 0, 0, 0);
        tick();
        check("lit_wr_collide_new", 32'(pres_state), 2);

        // Saturation of the narrow step counter.
        set_in(1, 0, 1, 2'b00);
        repeat (10) tick();
        check("lit_sat_cnt", 32'(step_cnt), CMAX);
        check("lit_sat_state", 32'(pres_state), 0);

        set_in(0, 0, 0, 2'b00);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
